seg_dyn_disp: RTL and testbench

- Display-side consumer of the meter datapath outputs: `price`, `point`, `sign`, `seg_en`.
- Converts the 20-bit binary value to six BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Applies leading-zero blanking, decimal points and a minus sign.
- Drives a 6-digit multiplexed seven-segment display, one digit per scan slot.

---
 rtl/seg_dyn_disp_if.sv | 20 ++
 rtl/seg_dyn_disp.sv | 195 +++++++++++++++++++
 tb/tb_seg_dyn_disp.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg_dyn_disp_if.sv
// Display bus for seg_dyn_disp: value/point/sign/enable inputs from the meter
// datapath and the multiplexed digit-select / segment outputs.
interface seg_dyn_disp_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (
    output data, point, sign, seg_en,
    input  sel, seg
  );

  modport slave (
    input  data, point, sign, seg_en,
    output sel, seg
  );
endinterface

// File: rtl/seg_dyn_disp.sv
// Six-digit multiplexed seven-segment driver: sequential double-dabble BCD
// conversion, leading-zero blanking, decimal points and minus sign.
module seg_dyn_disp #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  seg_dyn_disp_if.slave  bus
);

  localparam logic [19:0] DATA_MAX   = 20'd999_999;
  localparam logic [4:0]  SHIFT_LAST = 5'd19;
  localparam logic [2:0]  IDX_LAST   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [19:0] r_bin;
  logic [23:0] r_bcd;
  logic [4:0]  r_shcnt;
  logic        r_sign_snap;
  logic [5:0]  r_point_snap;

  logic [23:0] r_disp_dig;
  logic        r_disp_sign;
  logic [5:0]  r_disp_point;

  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [5:0]  r_sel;
  logic [7:0]  r_seg;

  logic [23:0] w_bcd_adj;
  logic [2:0]  w_hi;
  logic [3:0]  w_cur_dig;
  logic        w_cur_dp;
  logic [5:0]  w_sel_nxt;
  logic [7:0]  w_glyph;
  logic [7:0]  w_seg_nxt;

  function automatic logic [23:0] f_add3(input logic [23:0] bcd);
    logic [23:0] res;
    res = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] f_seg_code(input logic [3:0] dig);
    logic [7:0] code;
    case (dig)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  assign w_bcd_adj = f_add3(r_bcd);

  // Free-running converter: capture, 20 shift-add-3 steps, atomic display update
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_bin        <= 20'd0;
      r_bcd        <= 24'd0;
      r_shcnt      <= 5'd0;
      r_sign_snap  <= 1'b0;
      r_point_snap <= 6'd0;
      r_disp_dig   <= 24'd0;
      r_disp_sign  <= 1'b0;
      r_disp_point <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bin        <= (bus.data > DATA_MAX) ? DATA_MAX : bus.data;
          r_sign_snap  <= bus.sign;
          r_point_snap <= bus.point;
          r_bcd        <= 24'd0;
          r_shcnt      <= 5'd0;
          r_state      <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          if (r_shcnt == SHIFT_LAST) begin
            r_shcnt <= 5'd0;
            r_state <= S_DONE;
          end else begin
            r_shcnt <= r_shcnt + 5'd1;
          end
        end
        S_DONE: begin
          r_disp_dig   <= r_bcd;
          r_disp_sign  <= r_sign_snap;
          r_disp_point <= r_point_snap;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Highest digit that must be lit: top nonzero digit or top decimal point
  always_comb begin
    w_hi = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if ((r_disp_dig[i*4 +: 4] != 4'd0) || r_disp_point[i]) begin
        w_hi = 3'(i);
      end else begin
        w_hi = w_hi;
      end
    end
  end

  // Pattern for the digit currently being scanned
  always_comb begin
    w_cur_dig = 4'd0;
    w_cur_dp  = 1'b0;
    w_sel_nxt = 6'd0;
    case (r_idx)
      3'd0: begin w_cur_dig = r_disp_dig[3:0];   w_cur_dp = r_disp_point[0]; w_sel_nxt = 6'b000001; end
      3'd1: begin w_cur_dig = r_disp_dig[7:4];   w_cur_dp = r_disp_point[1]; w_sel_nxt = 6'b000010; end
      3'd2: begin w_cur_dig = r_disp_dig[11:8];  w_cur_dp = r_disp_point[2]; w_sel_nxt = 6'b000100; end
      3'd3: begin w_cur_dig = r_disp_dig[15:12]; w_cur_dp = r_disp_point[3]; w_sel_nxt = 6'b001000; end
      3'd4: begin w_cur_dig = r_disp_dig[19:16]; w_cur_dp = r_disp_point[4]; w_sel_nxt = 6'b010000; end
      3'd5: begin w_cur_dig = r_disp_dig[23:20]; w_cur_dp = r_disp_point[5]; w_sel_nxt = 6'b100000; end
      default: begin w_cur_dig = 4'd0; w_cur_dp = 1'b0; w_sel_nxt = 6'd0; end
    endcase

    // Minus sits just left of the top lit digit; dropped when hi is the last digit
    if (r_idx <= w_hi) begin
      w_glyph = f_seg_code(w_cur_dig);
    end else if (r_disp_sign && (r_idx == (w_hi + 3'd1))) begin
      w_glyph = 8'hBF;
    end else begin
      w_glyph = 8'hFF;
    end

    if (w_cur_dp) begin
      w_seg_nxt = {1'b0, w_glyph[6:0]};
    end else begin
      w_seg_nxt = w_glyph;
    end
  end

  // Scan slot timer and digit index
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= 16'd0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= 16'd0;
      r_idx <= (r_idx >= IDX_LAST) ? 3'd0 : (r_idx + 3'd1);
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Registered digit select and segments, blanked while disabled
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sel <= 6'd0;
      r_seg <= 8'hFF;
    end else if (bus.seg_en) begin
      r_sel <= w_sel_nxt;
      r_seg <= w_seg_nxt;
    end else begin
      r_sel <= 6'd0;
      r_seg <= 8'hFF;
    end
  end

  assign bus.sel = r_sel;
  assign bus.seg = r_seg;

endmodule

// File: tb/tb_seg_dyn_disp.sv
// Directed self-checking bench for seg_dyn_disp with a 10-cycle scan slot.
module tb_seg_dyn_disp;

  logic sys_clk;
  logic sys_rst;
  int   n_checks;
  int   n_errors;

  seg_dyn_disp_if u_if ();

  seg_dyn_disp #(.CNT_MAX(16'd9)) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // exp_segs = {digit5, ..., digit0}
  task automatic check_digits(input string tag, input logic [47:0] exp_segs);
    logic [5:0] want;
    int         cnt;
    for (int d = 0; d < 6; d++) begin
      want = 6'd1 << d;
      cnt  = 0;
      while ((u_if.sel !== want) && (cnt < 80)) begin
        @(negedge sys_clk);
        cnt++;
      end
      if (cnt >= 80) begin
        check_val($sformatf("%s_sel_timeout_d%0d", tag, d), {26'd0, u_if.sel}, {26'd0, want});
      end else begin
        check_val($sformatf("%s_d%0d", tag, d), {24'd0, u_if.seg}, {24'd0, exp_segs[d*8 +: 8]});
      end
    end
  endtask

  // Returns cycles until sel changes (bounded) and the new sel value
  task automatic wait_sel_change(output int cycles, output logic [5:0] new_sel);
    logic [5:0] prev;
    prev   = u_if.sel;
    cycles = 0;
    while ((u_if.sel === prev) && (cycles < 40)) begin
      @(negedge sys_clk);
      cycles++;
    end
    new_sel = u_if.sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cyc;
    logic [5:0] s_cur;
    logic [5:0] s_nxt;
    logic [5:0] s_held;

    n_checks     = 0;
    n_errors     = 0;
    sys_rst      = 1'b1;
    u_if.data    = 20'd0;
    u_if.point   = 6'd0;
    u_if.sign    = 1'b0;
    u_if.seg_en  = 1'b1;

    wait_clks(3);
    check_val("rst_sel", {26'd0, u_if.sel}, 32'h0);
    check_val("rst_seg", {24'd0, u_if.seg}, 32'hFF);

    // Release, then reset again mid-SHIFT
    sys_rst = 1'b0;
    wait_clks(10);
    check_val("run_sel_nonzero", {31'd0, (u_if.sel != 6'd0)}, 32'h1);
    sys_rst = 1'b1;
    #1;
    check_val("midrst_sel_async", {26'd0, u_if.sel}, 32'h0);
    check_val("midrst_seg_async", {24'd0, u_if.seg}, 32'hFF);
    wait_clks(2);
    check_val("midrst_sel_held", {26'd0, u_if.sel}, 32'h0);
    check_val("midrst_seg_held", {24'd0, u_if.seg}, 32'hFF);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_digits("post_rst", 48'hFFFF_FFFF_FFC0);

    // 123456 plain
    u_if.data = 20'd123456;
    wait_clks(44);
    check_digits("d123456", 48'hF9A4_B099_9282);

    // Slot stepping: 10 clocks per digit, one-hot rotating left
    wait_sel_change(cyc, s_cur);
    for (int k = 0; k < 7; k++) begin
      wait_sel_change(cyc, s_nxt);
      check_val($sformatf("step_len_%0d", k), cyc, 32'd10);
      check_val($sformatf("step_sel_%0d", k), {26'd0, s_nxt}, {26'd0, s_cur[4:0], s_cur[5]});
      s_cur = s_nxt;
    end

    // Sign shown left of top digit, then suppressed when all six digits used
    u_if.data = 20'd25;
    u_if.sign = 1'b1;
    wait_clks(44);
    check_digits("d25_neg", 48'hFFFF_FFBF_A492);
    u_if.data = 20'd100005;
    wait_clks(44);
    check_digits("d100005_neg", 48'hF9C0_C0C0_C092);

    // Decimal points extend the lit range
    u_if.sign  = 1'b0;
    u_if.data  = 20'd5;
    u_if.point = 6'b000100;
    wait_clks(44);
    check_digits("d5_pt2", 48'hFFFF_FF40_C092);
    u_if.data  = 20'd0;
    u_if.point = 6'b100000;
    wait_clks(44);
    check_digits("d0_pt5", 48'h40C0_C0C0_C0C0);

    // Clamp
    u_if.point = 6'd0;
    u_if.sign  = 1'b1;
    u_if.data  = 20'hFFFFF;
    wait_clks(44);
    check_digits("clamp", 48'h9090_9090_9090);
    u_if.data = 20'd999_999;
    wait_clks(44);
    check_digits("d999999", 48'h9090_9090_9090);

    // seg_en toggle mid-slot: blank next clock, same digit and slot timing after
    wait_sel_change(cyc, s_held);
    wait_clks(3);
    u_if.seg_en = 1'b0;
    @(negedge sys_clk);
    check_val("dis_sel", {26'd0, u_if.sel}, 32'h0);
    check_val("dis_seg", {24'd0, u_if.seg}, 32'hFF);
    wait_clks(2);
    u_if.seg_en = 1'b1;
    @(negedge sys_clk);
    check_val("reen_sel", {26'd0, u_if.sel}, {26'd0, s_held});
    check_val("reen_seg", {24'd0, u_if.seg}, 32'h90);
    wait_sel_change(cyc, s_nxt);
    check_val("reen_slot_rest", cyc, 32'd3);
    check_val("reen_next_sel", {26'd0, s_nxt}, {26'd0, s_held[4:0], s_held[5]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
